// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two cores' MEM stages, the arbiter and the shared
// single-port data memory. The arbiter connects through the slave modport.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] addr_i1, addr_i2;
  logic [DATA_W-1:0] data_i1, data_i2;
  logic              MemRead_i1, MemRead_i2;
  logic              MemWrite_i1, MemWrite_i2;
  logic              lock_i1, lock_i2;
  logic [DATA_W-1:0] data_o1, data_o2;
  logic              stall_o1, stall_o2;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_data_o;
  logic              mem_MemRead_o;
  logic              mem_MemWrite_o;
  logic [DATA_W-1:0] mem_data_i;
  logic [1:0]        owner_o;

  modport slave (
    input  addr_i1, addr_i2, data_i1, data_i2,
    input  MemRead_i1, MemRead_i2, MemWrite_i1, MemWrite_i2,
    input  lock_i1, lock_i2, mem_data_i,
    output data_o1, data_o2, stall_o1, stall_o2,
    output mem_addr_o, mem_data_o, mem_MemRead_o, mem_MemWrite_o, owner_o
  );

  modport master (
    output addr_i1, addr_i2, data_i1, data_i2,
    output MemRead_i1, MemRead_i2, MemWrite_i1, MemWrite_i2,
    output lock_i1, lock_i2, mem_data_i,
    input  data_o1, data_o2, stall_o1, stall_o2,
    input  mem_addr_o, mem_data_o, mem_MemRead_o, mem_MemWrite_o, owner_o
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter for two cores sharing one single-port data memory,
// with per-core exclusive locking and an idle-timeout forced release.
module dmem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int LOCK_TIMEOUT = 15
) (
  input  logic           clk_i,
  input  logic           rst_i,
  dmem_arbiter_if.slave  bus
);
  localparam int IDLE_W = $clog2(LOCK_TIMEOUT + 1);

  // Encoding doubles as the owner_o value.
  typedef enum logic [1:0] {
    UNLOCKED = 2'b00,
    LOCK1    = 2'b01,
    LOCK2    = 2'b10
  } state_t;

  state_t                       state_q, state_d;
  logic                         last2_q, last2_d;
  logic [IDLE_W-1:0]            idle_q, idle_d, idle_inc;
  logic [1:0][DATA_W-1:0]       hold_q, hold_d;

  logic [1:0]                   rd, wr, lk, req, grant, stall;
  logic [1:0][ADDR_W-1:0]       addr;
  logic [1:0][DATA_W-1:0]       wdata, rdata;

  assign rd    = {bus.MemRead_i2,  bus.MemRead_i1};
  assign wr    = {bus.MemWrite_i2, bus.MemWrite_i1};
  assign lk    = {bus.lock_i2,     bus.lock_i1};
  assign req   = rd | wr;
  assign addr  = {bus.addr_i2, bus.addr_i1};
  assign wdata = {bus.data_i2, bus.data_i1};

  // Nothing is granted while reset is held, so no write can slip out.
  always_comb begin
    grant = 2'b00;
    if (rst_i) begin
      case (state_q)
        UNLOCKED: grant = (req == 2'b11) ? (last2_q ? 2'b01 : 2'b10) : req;
        LOCK1:    grant = {1'b0, req[0]};
        LOCK2:    grant = {req[1], 1'b0};
        default:  grant = 2'b00;
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_core
      assign stall[gi]  = req[gi] & ~grant[gi];
      assign rdata[gi]  = (grant[gi] & rd[gi]) ? bus.mem_data_i : hold_q[gi];
      assign hold_d[gi] = rdata[gi];
    end
  endgenerate

  assign bus.stall_o1       = stall[0];
  assign bus.stall_o2       = stall[1];
  assign bus.data_o1        = rdata[0];
  assign bus.data_o2        = rdata[1];
  assign bus.mem_MemRead_o  = |(grant & rd);
  assign bus.mem_MemWrite_o = |(grant & wr);
  assign bus.mem_addr_o     = ({ADDR_W{grant[0]}} & addr[0]) | ({ADDR_W{grant[1]}} & addr[1]);
  assign bus.mem_data_o     = ({DATA_W{grant[0]}} & wdata[0]) | ({DATA_W{grant[1]}} & wdata[1]);
  assign bus.owner_o        = state_q;

  always_comb begin
    idle_inc = idle_q;
    if (idle_q != IDLE_W'(LOCK_TIMEOUT))
      idle_inc = idle_q + 1'b1;
  end

  always_comb begin
    state_d = state_q;
    last2_d = last2_q;
    idle_d  = idle_q;
    if (|grant)
      last2_d = grant[1];
    case (state_q)
      UNLOCKED: begin
        idle_d = '0;
        if (grant[0] & lk[0])
          state_d = LOCK1;
        else if (grant[1] & lk[1])
          state_d = LOCK2;
      end
      LOCK1, LOCK2: begin
        if (grant[state_q == LOCK2]) begin
          idle_d = '0;
          if (!lk[state_q == LOCK2])
            state_d = UNLOCKED;
        end else if (idle_inc == IDLE_W'(LOCK_TIMEOUT)) begin
          // Owner went quiet for too long: drop the lock so the other core can proceed.
          idle_d  = '0;
          state_d = UNLOCKED;
        end else begin
          idle_d = idle_inc;
        end
      end
      default: begin
        state_d = UNLOCKED;
        idle_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= UNLOCKED;
      last2_q <= 1'b1;
      idle_q  <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      last2_q <= last2_d;
      idle_q  <= idle_d;
      hold_q  <= hold_d;
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a behavioural shared memory, a vector table driven
// through a scoreboard queue, and hand sequences for lock timeout and reset.
module tb_dmem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  localparam logic [2:0] N  = 3'b000;  // {lock, write, read}
  localparam logic [2:0] R  = 3'b001;
  localparam logic [2:0] W  = 3'b010;
  localparam logic [2:0] RL = 3'b101;
  localparam logic [2:0] WL = 3'b110;

  typedef struct {
    logic [2:0]  c1;
    logic [31:0] a1, d1;
    logic [2:0]  c2;
    logic [31:0] a2, d2;
    logic [1:0]  st;    // {stall2, stall1}
    logic [1:0]  mrw;   // {mem_wr, mem_rd}
    logic [31:0] maddr, mdata;
    logic [1:0]  own;
    logic [31:0] o1, o2;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic mem_init = 1'b1;
  logic [DW-1:0] mem [0:63];
  int checks = 0;
  int errors = 0;
  vec_t sb[$];
  vec_t tbl[17];

  always #5 clk = ~clk;

  dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LOCK_TIMEOUT(15)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= DW'(i + 1);
    end else if (bus.mem_MemWrite_o) begin
      mem[bus.mem_addr_o[7:2]] <= bus.mem_data_o;
    end
  end
  assign bus.mem_data_i = mem[bus.mem_addr_o[7:2]];

  function automatic vec_t v(input logic [2:0] c1, input logic [31:0] a1, d1,
                             input logic [2:0] c2, input logic [31:0] a2, d2,
                             input logic [1:0] st, input logic [1:0] mrw,
                             input logic [31:0] maddr, mdata, input logic [1:0] own,
                             input logic [31:0] o1, o2);
    vec_t t;
    t.c1 = c1; t.a1 = a1; t.d1 = d1; t.c2 = c2; t.a2 = a2; t.d2 = d2;
    t.st = st; t.mrw = mrw; t.maddr = maddr; t.mdata = mdata; t.own = own;
    t.o1 = o1; t.o2 = o2;
    return t;
  endfunction

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    {bus.lock_i1, bus.MemWrite_i1, bus.MemRead_i1} = t.c1;
    {bus.lock_i2, bus.MemWrite_i2, bus.MemRead_i2} = t.c2;
    bus.addr_i1 = t.a1; bus.data_i1 = t.d1;
    bus.addr_i2 = t.a2; bus.data_i2 = t.d2;
  endtask

  task automatic step(input string tag, input vec_t t);
    vec_t e;
    @(posedge clk); #1;
    drive(t);
    sb.push_back(t);
    @(negedge clk);
    e = sb.pop_front();
    $display("%s: c1=%b c2=%b stall=%b mrw=%b maddr=%h own=%b o1=%h o2=%h", tag, e.c1, e.c2,
             {bus.stall_o2, bus.stall_o1}, {bus.mem_MemWrite_o, bus.mem_MemRead_o},
             bus.mem_addr_o, bus.owner_o, bus.data_o1, bus.data_o2);
    cmp({tag, ".stall"}, 32'({bus.stall_o2, bus.stall_o1}), 32'(e.st));
    cmp({tag, ".mrw"},   32'({bus.mem_MemWrite_o, bus.mem_MemRead_o}), 32'(e.mrw));
    cmp({tag, ".maddr"}, bus.mem_addr_o, e.maddr);
    cmp({tag, ".mdata"}, bus.mem_data_o, e.mdata);
    cmp({tag, ".owner"}, 32'(bus.owner_o), 32'(e.own));
    cmp({tag, ".data1"}, bus.data_o1, e.o1);
    cmp({tag, ".data2"}, bus.data_o2, e.o2);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tbl[0]  = v(N, 0, 0,        N, 0, 0,        2'b00, 2'b00, 0,     0,     2'b00, 0,     0);
    tbl[1]  = v(W, 'h10, 'hAA,  W, 'h14, 'hBB,  2'b10, 2'b10, 'h10,  'hAA,  2'b00, 0,     0);
    tbl[2]  = v(N, 0, 0,        W, 'h14, 'hBB,  2'b00, 2'b10, 'h14,  'hBB,  2'b00, 0,     0);
    tbl[3]  = v(R, 0, 0,        N, 0, 0,        2'b00, 2'b01, 0,     0,     2'b00, 1,     0);
    tbl[4]  = v(N, 0, 0,        N, 0, 0,        2'b00, 2'b00, 0,     0,     2'b00, 1,     0);
    tbl[5]  = v(R, 'h10, 0,     N, 0, 0,        2'b00, 2'b01, 'h10,  0,     2'b00, 'hAA,  0);
    tbl[6]  = v(N, 0, 0,        R, 'h14, 0,     2'b00, 2'b01, 'h14,  0,     2'b00, 'hAA,  'hBB);
    tbl[7]  = v(R, 0, 0,        R, 'h4, 0,      2'b10, 2'b01, 0,     0,     2'b00, 1,     'hBB);
    tbl[8]  = v(R, 0, 0,        R, 'h4, 0,      2'b01, 2'b01, 'h4,   0,     2'b00, 1,     2);
    tbl[9]  = v(R, 0, 0,        R, 'h4, 0,      2'b10, 2'b01, 0,     0,     2'b00, 1,     2);
    tbl[10] = v(R, 0, 0,        R, 'h4, 0,      2'b01, 2'b01, 'h4,   0,     2'b00, 1,     2);
    tbl[11] = v(R, 0, 0,        R, 'h4, 0,      2'b10, 2'b01, 0,     0,     2'b00, 1,     2);
    tbl[12] = v(R, 0, 0,        R, 'h4, 0,      2'b01, 2'b01, 'h4,   0,     2'b00, 1,     2);
    tbl[13] = v(R, 'h8, 0,      RL, 'h8, 0,     2'b10, 2'b01, 'h8,   0,     2'b00, 3,     2);
    tbl[14] = v(R, 'h8, 0,      RL, 'h8, 0,     2'b01, 2'b01, 'h8,   0,     2'b00, 3,     3);
    tbl[15] = v(R, 'h8, 0,      W, 'h8, 'h33,   2'b01, 2'b10, 'h8,   'h33,  2'b10, 3,     3);
    tbl[16] = v(R, 'h8, 0,      N, 0, 0,        2'b00, 2'b01, 'h8,   0,     2'b00, 'h33,  3);

    drive(tbl[0]);
    repeat (2) @(posedge clk);
    @(negedge clk);
    cmp("reset.owner", 32'(bus.owner_o), 0);
    cmp("reset.stall", 32'({bus.stall_o2, bus.stall_o1}), 0);
    cmp("reset.mrw",   32'({bus.mem_MemWrite_o, bus.mem_MemRead_o}), 0);
    cmp("reset.data1", bus.data_o1, 0);
    cmp("reset.data2", bus.data_o2, 0);
    mem_init = 1'b0;
    rst_n = 1'b1;

    for (int i = 0; i < 17; i++) step($sformatf("row%0d", i), tbl[i]);
    cmp("mem.0x10", mem[4], 'hAA);
    cmp("mem.0x14", mem[5], 'hBB);
    cmp("mem.0x08", mem[2], 'h33);

    // Core 1 locks then goes idle; core 2 waits out the timeout.
    step("tmo.lock", v(RL, 0, 0, N, 0, 0, 2'b00, 2'b01, 0, 0, 2'b00, 1, 3));
    for (int i = 1; i <= 15; i++)
      step($sformatf("tmo.idle%0d", i), v(N, 0, 0, R, 'h4, 0, 2'b10, 2'b00, 0, 0, 2'b01, 1, 3));
    step("tmo.release", v(N, 0, 0, R, 'h4, 0, 2'b00, 2'b01, 'h4, 0, 2'b00, 1, 2));
    step("tmo.idle", v(N, 0, 0, N, 0, 0, 2'b00, 2'b00, 0, 0, 2'b00, 1, 2));

    // Reset while core 1 holds the lock and presents a write.
    step("rst.lock", v(RL, 0, 0, N, 0, 0, 2'b00, 2'b01, 0, 0, 2'b00, 1, 2));
    @(posedge clk); #1;
    drive(v(WL, 'h20, 'h55, N, 0, 0, 2'b00, 2'b00, 0, 0, 2'b00, 0, 0));
    rst_n = 1'b0;
    @(negedge clk);
    cmp("rst.owner",  32'(bus.owner_o), 0);
    cmp("rst.mwr",    32'(bus.mem_MemWrite_o), 0);
    cmp("rst.data1",  bus.data_o1, 0);
    @(posedge clk); #1;
    drive(tbl[0]);
    rst_n = 1'b1;
    @(negedge clk);
    cmp("rst.mem0x20", mem[8], 9);
    cmp("rst.owner2",  32'(bus.owner_o), 0);
    step("post.write", v(W, 'h20, 'h77, N, 0, 0, 2'b00, 2'b10, 'h20, 'h77, 2'b00, 0, 0));
    @(negedge clk);
    cmp("post.mem0x20", mem[8], 'h77);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter placed between the two CPU cores' MEM stages and a single-port shared data memory. It picks one core's access per cycle using round-robin priority and stalls the losing core. It also supports a lock: one core can hold exclusive ownership across several accesses for atomic read-modify-write sequences, with a timeout that forces release if the owner stops issuing accesses.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- LOCK_TIMEOUT, 15, idle cycles of the lock owner before forced release (must be ≥1; counter width $clog2(LOCK_TIMEOUT+1))

Ports:
- clk_i  in  1  single clock; all state updates on rising edge
- rst_i  in  1  reset, asynchronous, active-low
- addr_i1 / addr_i2  in  ADDR_W  core 1 / core 2 byte address
- data_i1 / data_i2  in  DATA_W  core write data
- MemRead_i1 / MemRead_i2  in  1  core read request
- MemWrite_i1 / MemWrite_i2  in  1  core write request
- lock_i1 / lock_i2  in  1  core requests or keeps exclusive ownership with this access
- data_o1 / data_o2  out  DATA_W  read data returned to the core
- stall_o1 / stall_o2  out  1  access not granted this cycle; the core holds its request
- mem_addr_o  out  ADDR_W  shared memory address
- mem_data_o  out  DATA_W  shared memory write data
- mem_MemRead_o  out  1  shared memory read enable
- mem_MemWrite_o  out  1  shared memory write enable (memory writes on the rising edge)
- mem_data_i  in  DATA_W  shared memory combinational read data
- owner_o  out  2  lock owner: 00 none, 01 core 1, 10 core 2

## Operation
- Request: reqN = MemRead_iN | MemWrite_iN. If a core asserts both, it is treated as a write and the read data is also returned.
- Registers:
  - state: UNLOCKED, LOCK1, LOCK2
  - last_grant pointer: 1 or 2
  - idle counter
  - hold registers for data_o1/data_o2
- Grant (combinational):
  - UNLOCKED, one request: that core is granted.
  - UNLOCKED, both requesting: the core ≠ last_grant is granted.
  - LOCKn: only core n can be granted. The other core is stalled whenever it requests.
- stall_oN = reqN & ~grantN.
- Memory outputs: mem_* are driven from the granted core. With no grant, all mem_* outputs are 0.
- Read data:
  - When a core has a granted read, data_oN = mem_data_i (combinational), and the hold register captures it at the clock edge.
  - Otherwise data_oN = hold register.
- last_grant updates to the granted core on every granted cycle and holds otherwise.
- Lock transitions (at the clock edge):
  - UNLOCKED → LOCKn when core n is granted with lock_in=1.
  - LOCKn → UNLOCKED when core n is granted with lock_in=0. That access completes normally.
  - LOCKn → UNLOCKED when the idle counter reaches LOCK_TIMEOUT (forced release).
- Idle counter:
  - Cleared on entry to LOCKn and on every owner access.
  - Increments on each LOCKn cycle with no owner request.
  - Saturates; it is 0 in UNLOCKED.
- owner_o reflects state.
- The arbiter has no address decode. Word alignment is the cores' responsibility.

## Timing
- Reset (rst_i=0, asynchronous): state=UNLOCKED, last_grant=2 (so core 1 wins the first tie), idle counter=0, hold registers=0, owner_o=00. With no requests, stall_o*=0, mem_*=0, and data_o*=0.
- A single uncontended access has zero added latency: grant, memory access and stall_o=0 all happen in the same cycle.
- Contention costs the loser exactly one stall cycle. It is granted the next cycle if it still requests, unless a lock is held.
- Under continuous contention with no locks, grants strictly alternate 1,2,1,2…
- A lock taken at edge k makes the other core stall from cycle k+1. After release at edge r, the other core can be granted in cycle r+1.
- After a forced release, a later owner access with lock_in=1 re-arbitrates as normal (no priority).
- Reset mid-lock: the lock clears immediately and no memory write is issued while rst_i=0.
- Reset mid-stall: the stalled request is dropped and the core must re-present it.

## Test plan
- Reset, then core 1 reads addr 0x0 (memory holds 1) alone → stall_o1=0, data_o1=1 in the same cycle, and data_o1 holds 1 after MemRead_i1 drops.
- Both cores write in cycle 0 (core 1: 0x10←0xAA, core 2: 0x14←0xBB) →
  - cycle 0: core 1 granted, stall_o2=1.
  - cycle 1: core 2 granted.
  - Memory ends with both values.
- Both cores read continuously for 6 cycles → grants alternate 1,2,1,2,1,2 and each stall_oN pulses every other cycle.
- Core 2 performs a locked RMW: read 0x8 with lock_i2=1, then write 0x8 with lock_i2=0, while core 1 requests 0x8 throughout →
  - owner_o=10 for one cycle.
  - Core 1 is stalled until the write completes.
  - Core 1 then reads the updated value.
- Core 1 locks and goes idle, with LOCK_TIMEOUT=15 and core 2 requesting → core 2 stalls for 15 idle cycles, owner_o returns to 00, and core 2 is granted the following cycle.
- Assert rst_i=0 while in LOCK1 with a pending write → owner_o=00 immediately, mem_MemWrite_o=0, and memory is unchanged.
